task_dispatch_sorter: RTL and testbench

Downstream consumer of the per-task control blocks. Each task block presents an 8-bit `{task_id[3:0], priority[3:0]}` word; a zero word means the task is not Ready. This block scans all entries and selects the highest-priority Ready task. It then issues a 16-bit Execute opcode on the shared op bus, holds the task for a time quantum, and issues the matching Finish-execution opcode. Equal priorities are arbitrated round-robin.

---
 rtl/sched_pkg.sv | 24 ++
 rtl/prio_compare.sv | 39 +++
 rtl/task_dispatch_sorter.sv | 189 ++++++++++++++++++
 tb/tb_task_dispatch_sorter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared definitions for the task dispatch sorter: FSM encoding, op codes,
// task entry field positions and the op-bus word builder.
package sched_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam logic [3:0] OP_EXEC   = 4'h7;
    localparam logic [3:0] OP_FINISH = 4'hF;

    localparam int ID_MSB   = 7;
    localparam int ID_LSB   = 4;
    localparam int PRIO_MSB = 3;
    localparam int PRIO_LSB = 0;

    // Op-bus word: {4'h0, id, op, 4'h0}
    function automatic logic [15:0] make_op(input logic [3:0] id, input logic [3:0] op);
        return {4'h0, id, op, 4'h0};
    endfunction

endpackage

// File: rtl/prio_compare.sv
// Combinational best-vs-candidate compare. A Ready candidate wins only when
// nothing is held yet or its priority is strictly higher, so earlier entries keep ties.
module prio_compare
    import sched_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic             best_valid,
    input  logic [3:0]       best_id,
    input  logic [3:0]       best_prio,
    input  logic [IDX_W-1:0] best_idx,
    input  logic [7:0]       cand_entry,
    input  logic [IDX_W-1:0] cand_idx,
    output logic             win_valid,
    output logic [3:0]       win_id,
    output logic [3:0]       win_prio,
    output logic [IDX_W-1:0] win_idx
);

    logic take_s;

    // Select between held best and the candidate entry
    always_comb begin
        take_s = (cand_entry != 8'h00) &&
                 (!best_valid || (cand_entry[PRIO_MSB:PRIO_LSB] > best_prio));
        if (take_s) begin
            win_valid = 1'b1;
            win_id    = cand_entry[ID_MSB:ID_LSB];
            win_prio  = cand_entry[PRIO_MSB:PRIO_LSB];
            win_idx   = cand_idx;
        end else begin
            win_valid = best_valid;
            win_id    = best_id;
            win_prio  = best_prio;
            win_idx   = best_idx;
        end
    end

endmodule

// File: rtl/task_dispatch_sorter.sv
// Scans task entries round-robin, dispatches the highest-priority Ready task
// with an Execute op, runs it for a quantum, then issues the Finish op.
module task_dispatch_sorter
    import sched_pkg::*;
#(
    parameter int N_TASKS = 8,
    parameter int QUANTUM = 10000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [8*N_TASKS-1:0] in_tasks,
    output logic [15:0]          out_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           cur_task,
    output logic                 busy
);

    localparam int               IDX_W    = $clog2(N_TASKS);
    localparam int               CNT_W    = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TASKS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] scan_cnt_r;
    logic [IDX_W-1:0] scan_idx_r;
    logic             best_valid_r;
    logic [3:0]       best_id_r;
    logic [3:0]       best_prio_r;
    logic [IDX_W-1:0] best_idx_r;
    logic [3:0]       win_id_r;
    logic [IDX_W-1:0] win_idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic [15:0]      out_op_r;
    logic             out_valid_r;
    logic [3:0]       cur_task_r;
    logic             busy_r;

    logic [7:0]       scan_entry_s;
    logic [7:0]       win_entry_s;
    logic             cmp_valid_s;
    logic [3:0]       cmp_id_s;
    logic [3:0]       cmp_prio_s;
    logic [IDX_W-1:0] cmp_idx_s;

    assign scan_entry_s = in_tasks[{scan_idx_r, 3'b000} +: 8];
    assign win_entry_s  = in_tasks[{win_idx_r, 3'b000} +: 8];

    prio_compare #(
        .IDX_W (IDX_W)
    ) u_prio_compare (
        .best_valid (best_valid_r),
        .best_id    (best_id_r),
        .best_prio  (best_prio_r),
        .best_idx   (best_idx_r),
        .cand_entry (scan_entry_s),
        .cand_idx   (scan_idx_r),
        .win_valid  (cmp_valid_s),
        .win_id     (cmp_id_s),
        .win_prio   (cmp_prio_s),
        .win_idx    (cmp_idx_s)
    );

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: next_state_s = ST_SCAN;
            ST_SCAN: begin
                if (scan_cnt_r == IDX_LAST) begin
                    next_state_s = cmp_valid_s ? ST_ISSUE : ST_IDLE;
                end else begin
                    next_state_s = ST_SCAN;
                end
            end
            ST_ISSUE: begin
                if (out_ready) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_RUN: begin
                // A task that dropped out of Ready is finished early
                if ((win_entry_s == 8'h00) || (cnt_r == CNT_LAST)) begin
                    next_state_s = ST_FINISH;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FINISH: begin
                if (out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FINISH;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, scan bookkeeping and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            scan_cnt_r   <= '0;
            scan_idx_r   <= '0;
            best_valid_r <= 1'b0;
            best_id_r    <= 4'h0;
            best_prio_r  <= 4'h0;
            best_idx_r   <= '0;
            win_id_r     <= 4'h0;
            win_idx_r    <= '0;
            cnt_r        <= '0;
            out_op_r     <= 16'h0000;
            out_valid_r  <= 1'b0;
            cur_task_r   <= 4'h0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    scan_cnt_r   <= '0;
                    scan_idx_r   <= rr_ptr_r;
                    best_valid_r <= 1'b0;
                    best_id_r    <= 4'h0;
                    best_prio_r  <= 4'h0;
                    best_idx_r   <= '0;
                    out_op_r     <= 16'h0000;
                    out_valid_r  <= 1'b0;
                end
                ST_SCAN: begin
                    best_valid_r <= cmp_valid_s;
                    best_id_r    <= cmp_id_s;
                    best_prio_r  <= cmp_prio_s;
                    best_idx_r   <= cmp_idx_s;
                    scan_cnt_r   <= scan_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    scan_idx_r   <= (scan_idx_r == IDX_LAST) ? '0
                                    : scan_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    if ((scan_cnt_r == IDX_LAST) && cmp_valid_s) begin
                        win_id_r    <= cmp_id_s;
                        win_idx_r   <= cmp_idx_s;
                        out_op_r    <= make_op(cmp_id_s, OP_EXEC);
                        out_valid_r <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (out_ready) begin
                        cur_task_r  <= win_id_r;
                        cnt_r       <= '0;
                        rr_ptr_r    <= (win_idx_r == IDX_LAST) ? '0
                                       : win_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        out_op_r    <= 16'h0000;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (next_state_s == ST_FINISH) begin
                        out_op_r    <= make_op(win_id_r, OP_FINISH);
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_FINISH: begin
                    if (out_ready) begin
                        cur_task_r  <= 4'h0;
                        out_op_r    <= 16'h0000;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_op_r    <= 16'h0000;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_op    = out_op_r;
    assign out_valid = out_valid_r;
    assign cur_task  = cur_task_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_task_dispatch_sorter.sv
// Directed bench for task_dispatch_sorter with hand-computed opcodes and
// round-robin order (N_TASKS = 8, QUANTUM = 12).
module tb_task_dispatch_sorter;

    localparam int N = 8;
    localparam int Q = 12;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [8*N-1:0] in_tasks = '0;
    logic [15:0]   out_op;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    cur_task;
    logic          busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task_dispatch_sorter #(.N_TASKS(N), .QUANTUM(Q)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_tasks  (in_tasks),
        .out_op    (out_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cur_task  (cur_task),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_entry(input int k, input logic [7:0] v);
        in_tasks[8*k +: 8] = v;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, {15'h0, out_valid}, 16'h0001);
    endtask

    initial begin
        int run_len;
        logic stable;
        logic [3:0] tie_ids [4];
        tie_ids[0] = 4'h3; tie_ids[1] = 4'h1; tie_ids[2] = 4'h3; tie_ids[3] = 4'h1;

        // Reset state
        tick(); tick();
        check("rst_valid", {15'h0, out_valid}, 16'h0000);
        check("rst_op", out_op, 16'h0000);
        check("rst_cur", {12'h0, cur_task}, 16'h0000);
        check("rst_busy", {15'h0, busy}, 16'h0000);

        // Single Ready task: entry 2 = 8'h35
        set_entry(2, 8'h35);
        out_ready = 1'b1;
        RST_N = 1'b1;
        wait_valid("single_exec_timeout", N + 4);
        check("single_exec_op", out_op, 16'h0370);
        tick();
        check("single_cur", {12'h0, cur_task}, 16'h0003);
        check("single_busy", {15'h0, busy}, 16'h0001);
        run_len = 0;
        while (out_valid !== 1'b1 && run_len < 40) begin
            tick();
            run_len++;
        end
        check("single_run_len", 16'(run_len), 16'(Q));
        check("single_fin_op", out_op, 16'h03F0);
        check("single_fin_cur", {12'h0, cur_task}, 16'h0003);
        tick();
        check("single_after_cur", {12'h0, cur_task}, 16'h0000);
        check("single_after_valid", {15'h0, out_valid}, 16'h0000);

        // Priority select; scan starts at entry 3, id 2 prio 9 wins
        in_tasks = '0;
        set_entry(0, 8'h12);
        set_entry(1, 8'h29);
        set_entry(4, 8'h47);
        wait_valid("prio_exec_timeout", N + 4);
        check("prio_exec_op", out_op, 16'h0270);
        tick();
        wait_valid("prio_fin_timeout", Q + 4);
        check("prio_fin_op", out_op, 16'h02F0);
        tick();

        // Round-robin tie; pointer is at entry 2, so id 3 goes first
        in_tasks = '0;
        set_entry(1, 8'h15);
        set_entry(3, 8'h35);
        for (int r = 0; r < 4; r++) begin
            wait_valid("tie_exec_timeout", N + 4);
            check($sformatf("tie_exec_%0d", r), out_op, {4'h0, tie_ids[r], 4'h7, 4'h0});
            tick();
            wait_valid("tie_fin_timeout", Q + 4);
            tick();
        end

        // Back-pressure in ISSUE
        in_tasks = '0;
        set_entry(5, 8'h6A);
        out_ready = 1'b0;
        wait_valid("bp_exec_timeout", N + 4);
        check("bp_exec_op", out_op, 16'h0670);
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid !== 1'b1 || out_op !== 16'h0670) stable = 1'b0;
        end
        check("bp_stable", {15'h0, stable}, 16'h0001);
        out_ready = 1'b1;
        tick();
        check("bp_cur", {12'h0, cur_task}, 16'h0006);
        check("bp_valid_drop", {15'h0, out_valid}, 16'h0000);
        check("bp_op_drop", out_op, 16'h0000);

        // Early exit: winner drops out of Ready mid-RUN
        tick(); tick(); tick();
        set_entry(5, 8'h00);
        wait_valid("early_fin_timeout", 2);
        check("early_fin_op", out_op, 16'h06F0);
        check("early_cur", {12'h0, cur_task}, 16'h0006);
        tick();
        check("early_after_cur", {12'h0, cur_task}, 16'h0000);

        // Reset while Finish is pending; pointer would otherwise be 3
        set_entry(2, 8'h35);
        wait_valid("rst_exec_timeout", N + 4);
        check("rst_exec_op", out_op, 16'h0370);
        tick();
        out_ready = 1'b0;
        wait_valid("rst_fin_timeout", Q + 4);
        check("rst_fin_op", out_op, 16'h03F0);
        tick(); tick();
        RST_N = 1'b0;
        tick();
        check("midrst_valid", {15'h0, out_valid}, 16'h0000);
        check("midrst_op", out_op, 16'h0000);
        check("midrst_cur", {12'h0, cur_task}, 16'h0000);
        check("midrst_busy", {15'h0, busy}, 16'h0000);
        in_tasks = '0;
        set_entry(1, 8'h15);
        set_entry(3, 8'h35);
        out_ready = 1'b1;
        RST_N = 1'b1;
        wait_valid("postrst_exec_timeout", N + 4);
        check("postrst_exec_op", out_op, 16'h0170);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
